// File: rtl/z80_uart_fifo.sv
// z80_uart_fifo: Z80 memory-mapped UART with TX/RX FIFOs, optional parity and a status/control register
module z80_uart_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ena,
    input  logic       i_addr,
    input  logic       i_rdn,
    input  logic       i_wrn,
    input  logic [7:0] i_dmaster,
    output logic [7:0] o_dslave,
    output logic       o_mwait,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_irq
);
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [7:0]    r_tx_mem [TX_DEPTH];
    logic [TA-1:0] r_tx_wp, r_tx_rp;
    logic [TA:0]   r_txf_cnt;
    logic [7:0]    r_rx_mem [RX_DEPTH];
    logic [RA-1:0] r_rx_wp, r_rx_rp;
    logic [RA:0]   r_rxf_cnt;

    logic          r_done, r_ie_rx, r_ie_tx, r_ovr, r_frm_err, r_par_err;
    logic [7:0]    r_latch;

    state_t        r_tx_st, r_rx_st;
    logic [CW-1:0] r_tx_clk, r_rx_clk;
    logic [2:0]    r_tx_bit, r_rx_bit;
    logic [7:0]    r_tx_sh, r_rx_sh;
    logic          r_tx_par, r_rx_pb, r_rx_s1, r_rx_s2;

    logic       w_rd, w_wr, w_stall, w_acc, w_st_wr;
    logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_idle;
    logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic       w_tx_last, w_rx_last, w_rx_done, w_ovr_set, w_frm_set, w_par_set;
    logic [7:0] w_status, w_rd_val;

    assign w_tx_empty = r_txf_cnt == '0;
    assign w_tx_full  = r_txf_cnt == (TA+1)'(TX_DEPTH);
    assign w_rx_empty = r_rxf_cnt == '0;
    assign w_rx_full  = r_rxf_cnt == (RA+1)'(RX_DEPTH);
    assign w_tx_idle  = w_tx_empty & (r_tx_st == S_IDLE);

    // One access per strobe: r_done blocks repeats until ena drops or the strobe rises
    assign w_rd    = i_ena & ~i_rdn;
    assign w_wr    = i_ena & ~i_wrn;
    assign w_stall = ~r_done & ~i_addr & ((w_rd & w_rx_empty) | (w_wr & w_tx_full));
    assign w_acc   = (w_rd | w_wr) & ~r_done & ~w_stall;
    assign w_st_wr  = w_acc & w_wr & i_addr;
    assign w_tx_push = w_acc & w_wr & ~i_addr;
    assign w_rx_pop  = w_acc & w_rd & ~i_addr;

    assign w_status = {r_ie_tx, r_ie_rx, w_tx_idle, r_par_err, r_frm_err, r_ovr, ~w_tx_full, ~w_rx_empty};
    assign w_rd_val = i_addr ? w_status : r_rx_mem[r_rx_rp];
    assign o_dslave = r_done ? r_latch : (w_rd ? w_rd_val : 8'h00);
    assign o_mwait  = ~w_stall;
    assign o_irq    = (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty);

    // A CPU pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_rx_last = r_rx_clk == LAST;
    assign w_rx_done = (r_rx_st == S_STOP) & w_rx_last;
    assign w_rx_push = w_rx_done & (~w_rx_full | w_rx_pop);
    assign w_ovr_set = w_rx_done & w_rx_full & ~w_rx_pop;
    assign w_frm_set = w_rx_done & ~r_rx_s2;
    assign w_par_set = w_rx_done & (PARITY_EN != 0) & (r_rx_pb ^ (^r_rx_sh) ^ 1'(PARITY_ODD));

    assign w_tx_last = r_tx_clk == LAST;
    assign w_tx_pop  = ~w_tx_empty & ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_last));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_latch   <= 8'h00;
            r_ie_rx   <= 1'b0;
            r_ie_tx   <= 1'b0;
            r_ovr     <= 1'b0;
            r_frm_err <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_done    <= (w_rd | w_wr) & (r_done | w_acc);
            if (w_acc) r_latch <= w_rd ? w_rd_val : 8'h00;
            if (w_st_wr) {r_ie_tx, r_ie_rx} <= i_dmaster[7:6];
            r_ovr     <= w_ovr_set | (r_ovr & ~(w_st_wr & i_dmaster[2]));
            r_frm_err <= w_frm_set | (r_frm_err & ~(w_st_wr & i_dmaster[3]));
            r_par_err <= w_par_set | (r_par_err & ~(w_st_wr & i_dmaster[4]));
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_dmaster;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_txf_cnt <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_rxf_cnt <= '0;
        end else begin
            r_tx_wp   <= w_tx_push ? r_tx_wp + TA'(1) : r_tx_wp;
            r_tx_rp   <= w_tx_pop ? r_tx_rp + TA'(1) : r_tx_rp;
            r_txf_cnt <= r_txf_cnt + (TA+1)'(w_tx_push) - (TA+1)'(w_tx_pop);
            r_rx_wp   <= w_rx_push ? r_rx_wp + RA'(1) : r_rx_wp;
            r_rx_rp   <= w_rx_pop ? r_rx_rp + RA'(1) : r_rx_rp;
            r_rxf_cnt <= r_rxf_cnt + (RA+1)'(w_rx_push) - (RA+1)'(w_rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_st  <= S_IDLE;
            o_tx     <= 1'b1;
            r_tx_clk <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= 8'h00;
            r_tx_par <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_st  <= S_START;
            o_tx     <= 1'b0;
            r_tx_clk <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= r_tx_mem[r_tx_rp];
            r_tx_par <= (^r_tx_mem[r_tx_rp]) ^ 1'(PARITY_ODD);
        end else begin
            r_tx_clk <= w_tx_last ? '0 : r_tx_clk + CW'(1);
            if (w_tx_last) begin
                case (r_tx_st)
                    S_START: begin
                        r_tx_st <= S_DATA;
                        o_tx    <= r_tx_sh[0];
                    end
                    S_DATA: begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        r_tx_sh  <= r_tx_sh >> 1;
                        o_tx     <= (r_tx_bit == 3'd7) ? ((PARITY_EN != 0) ? r_tx_par : 1'b1) : r_tx_sh[1];
                        if (r_tx_bit == 3'd7) r_tx_st <= (PARITY_EN != 0) ? S_PAR : S_STOP;
                    end
                    S_PAR: begin
                        r_tx_st <= S_STOP;
                        o_tx    <= 1'b1;
                    end
                    S_STOP: r_tx_st <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // START re-checks the line mid-bit; later samples are spaced one bit apart from there
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_st  <= S_IDLE;
            r_rx_clk <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= 8'h00;
            r_rx_pb  <= 1'b0;
        end else begin
            case (r_rx_st)
                S_IDLE: begin
                    r_rx_clk <= '0;
                    if (!r_rx_s2) r_rx_st <= S_START;
                end
                S_START: begin
                    r_rx_clk <= (r_rx_clk == HALF) ? '0 : r_rx_clk + CW'(1);
                    r_rx_bit <= '0;
                    if (r_rx_clk == HALF) r_rx_st <= r_rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    r_rx_clk <= w_rx_last ? '0 : r_rx_clk + CW'(1);
                    if (w_rx_last) begin
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_st <= (PARITY_EN != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    r_rx_clk <= w_rx_last ? '0 : r_rx_clk + CW'(1);
                    if (w_rx_last) begin
                        r_rx_pb <= r_rx_s2;
                        r_rx_st <= S_STOP;
                    end
                end
                default: begin
                    r_rx_clk <= w_rx_last ? '0 : r_rx_clk + CW'(1);
                    if (w_rx_last) r_rx_st <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_z80_uart_fifo.sv
// tb_z80_uart_fifo: directed bench for z80_uart_fifo (4 clocks/bit, depth 4, plus an even-parity instance)
module tb_z80_uart_fifo;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       bus_en = 1'b0, psel = 1'b0, addr = 1'b0, rdn = 1'b1, wrn = 1'b1, rx_drv = 1'b1;
    logic [7:0] dmaster = 8'h00;
    logic       ena, p_ena, rx, p_rx, mwait, p_mwait, tx, p_tx, irq, p_irq, cur_mwait;
    logic [7:0] dslave, p_dslave, cur_dslave;
    int         n_chk = 0, n_pass = 0, cyc = 0;
    logic [7:0] tx_bytes [6] = '{8'h55, 8'hA3, 8'h01, 8'hFF, 8'h10, 8'h7E};

    assign ena        = bus_en & ~psel;
    assign p_ena      = bus_en & psel;
    assign rx         = psel ? 1'b1 : rx_drv;
    assign p_rx       = psel ? rx_drv : 1'b1;
    assign cur_mwait  = psel ? p_mwait : mwait;
    assign cur_dslave = psel ? p_dslave : dslave;

    z80_uart_fifo #(.CLKS_PER_BIT(4), .TX_DEPTH(4), .RX_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_addr(addr), .i_rdn(rdn), .i_wrn(wrn),
        .i_dmaster(dmaster), .o_dslave(dslave), .o_mwait(mwait), .i_rx(rx), .o_tx(tx), .o_irq(irq));

    z80_uart_fifo #(.CLKS_PER_BIT(4), .TX_DEPTH(4), .RX_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .i_ena(p_ena), .i_addr(addr), .i_rdn(rdn), .i_wrn(wrn),
        .i_dmaster(dmaster), .o_dslave(p_dslave), .o_mwait(p_mwait), .i_rx(p_rx), .o_tx(p_tx), .o_irq(p_irq));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d, output int st, output bit ok);
        @(negedge clk);
        bus_en = 1'b1; addr = a; dmaster = d; wrn = 1'b0; st = 0;
        #1;
        while (!cur_mwait && st < 200) begin
            @(negedge clk); #1; st++;
        end
        ok = cur_mwait;
        if (ok) @(negedge clk);
        wrn = 1'b1; bus_en = 1'b0;
    endtask

    task automatic bus_read(input logic a, input int hold, input int budget,
                            output logic [7:0] d, output logic [7:0] d2, output int st, output bit ok);
        @(negedge clk);
        bus_en = 1'b1; addr = a; rdn = 1'b0; st = 0; d = 8'h00; d2 = 8'h00;
        #1;
        while (!cur_mwait && st < budget) begin
            @(negedge clk); #1; st++;
        end
        ok = cur_mwait;
        if (ok) begin
            @(negedge clk); #1;
            d = cur_dslave;
            repeat (hold) @(negedge clk);
            #1;
            d2 = cur_dslave;
        end
        rdn = 1'b1; bus_en = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        int  st;
        bit  ok;
        bus_write(a, d, st, ok);
        if (!ok) chk("wr_timeout", 0, 1);
    endtask

    task automatic rd(input string tag, input logic a, input logic [7:0] exp);
        logic [7:0] d, d2;
        int         st;
        bit         ok;
        bus_read(a, 0, 200, d, d2, st, ok);
        if (!ok) chk({tag, "_timeout"}, 0, 1);
        chk(tag, d, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic pb, input logic sb);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (4) @(negedge clk);
        end
        if (psel) begin
            rx_drv = pb;
            repeat (4) @(negedge clk);
        end
        rx_drv = sb;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic tx_frame(output logic [7:0] b, output int t0, output bit ok);
        int n = 0;
        b = 8'h00;
        @(negedge clk);
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk); n++;
        end
        ok = (tx === 1'b0);
        t0 = cyc;
        if (!ok) return;
        @(negedge clk);
        chk("tx_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = tx;
        end
        repeat (4) @(negedge clk);
        chk("tx_stop", tx, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wr(1'b0, 8'h55);
        @(negedge clk);
        chk("tx_busy", tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_mwait", mwait, 1);
        chk("rst_irq", irq, 0);
        chk("rst_dslave", dslave, 8'h00);
        rst_n = 1'b1;
        rd("rst_status", 1'b1, 8'h22);
        repeat (50) @(negedge clk);
        chk("rst_tx_quiet", tx, 1);

        fork
            begin
                int st;
                bit ok;
                for (int i = 0; i < 6; i++) begin
                    bus_write(1'b0, tx_bytes[i], st, ok);
                    if (!ok) chk($sformatf("tx_wr%0d_timeout", i), 0, 1);
                    if (i == 4) chk("tx_no_stall5", st, 0);
                    if (i == 5) chk("tx_stall6", st > 0, 1);
                end
            end
            begin
                logic [7:0] b;
                int         t, tp;
                bit         ok;
                tp = 0;
                for (int k = 0; k < 6; k++) begin
                    tx_frame(b, t, ok);
                    if (!ok) chk($sformatf("tx_frame%0d_timeout", k), 0, 1);
                    chk($sformatf("tx_byte%0d", k), b, tx_bytes[k]);
                    if (k > 0) chk($sformatf("tx_spacing%0d", k), (t - tp >= 40) && (t - tp <= 41), 1);
                    tp = t;
                end
            end
        join
        repeat (6) @(negedge clk);
        rd("burst_status", 1'b1, 8'h22);

        fork
            begin
                logic [7:0] d, d2;
                int         st;
                bit         ok;
                bus_read(1'b0, 3, 200, d, d2, st, ok);
                chk("rxw_accepted", ok, 1);
                chk("rxw_stalled", st > 0, 1);
                chk("rxw_data", d, 8'h3C);
                chk("rxw_stable", d2, 8'h3C);
            end
            begin
                repeat (3) @(negedge clk);
                send_rx(8'h3C, 1'b0, 1'b1);
            end
        join
        rd("rxw_status", 1'b1, 8'h22);

        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rd("ovr_status", 1'b1, 8'h27);
        for (int i = 1; i <= 4; i++) rd($sformatf("ovr_data%0d", i), 1'b0, 8'(i));
        begin
            logic [7:0] d, d2;
            int         st;
            bit         ok;
            bus_read(1'b0, 0, 20, d, d2, st, ok);
            chk("ovr_fifth_stalls", ok, 0);
        end
        wr(1'b1, 8'h04);
        rd("ovr_cleared", 1'b1, 8'h22);

        psel = 1'b1;
        send_rx(8'h07, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rd("par_status", 1'b1, 8'h33);
        rd("par_data", 1'b0, 8'h07);
        send_rx(8'h00, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        rd("frm_status", 1'b1, 8'h3B);
        rd("frm_data", 1'b0, 8'h00);
        wr(1'b1, 8'h1C);
        rd("err_cleared", 1'b1, 8'h22);
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        rd("glitch_status", 1'b1, 8'h22);
        send_rx(8'h07, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rd("par_ok_status", 1'b1, 8'h23);
        rd("par_ok_data", 1'b0, 8'h07);
        psel = 1'b0;

        wr(1'b1, 8'h40);
        chk("irq_ie_rx_empty", irq, 0);
        send_rx(8'h99, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("irq_rx", irq, 1);
        rd("irq_data", 1'b0, 8'h99);
        chk("irq_after_pop", irq, 0);
        rd("irq_status", 1'b1, 8'h62);
        wr(1'b1, 8'hC0);
        chk("irq_tx_empty", irq, 1);
        wr(1'b1, 8'h00);
        chk("irq_off", irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
